// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory bus around the
// instruction/data memory port arbiter. The master view belongs to the
// arbiter; the slave view belongs to the requesters and the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_wait;
  logic              i_segv;
  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_wait;
  logic              d_segv;
  // Shared single-ported memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_valid, i_wait, i_segv,
    output d_rdata, d_valid, d_wait, d_segv,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_valid, i_wait, i_segv,
    input  d_rdata, d_valid, d_wait, d_segv,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the instruction-fetch (I) and
// load/store (D) requesters. Round-robin grant, bounds/alignment fault check
// before any bus cycle, and a watchdog that faults an access whose ack never
// arrives. All outputs are registered except the two wait signals.
module mem_port_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = 'h0001_0000,
  parameter int                TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP, FAULT} state_t;
  typedef enum logic {REQ_I, REQ_D} req_t;

  state_t            state_q;
  req_t              last_gnt_q;
  cnt_t              cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              i_segv_q;
  logic              d_segv_q;

  req_t              gnt_d;
  logic              any_req_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic              sel_fault_d;

  // Out of range (unsigned compare) or not word aligned.
  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    return (a >= MEM_LIMIT) || (a[1:0] != 2'b00);
  endfunction

  // Grant choice for the next IDLE cycle: a lone requester wins, a tie goes
  // to whoever was not served last.
  always_comb begin
    gnt_d       = REQ_I;
    any_req_d   = bus.i_req | bus.d_req;
    if (bus.i_req && bus.d_req)
      gnt_d = (last_gnt_q == REQ_I) ? REQ_D : REQ_I;
    else if (bus.d_req)
      gnt_d = REQ_D;
    sel_addr_d  = (gnt_d == REQ_D) ? bus.d_addr : bus.i_addr;
    sel_fault_d = addr_fault(sel_addr_d);
  end

  // Arbitration FSM with all bus and requester outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= REQ_I;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_segv_q    <= 1'b0;
      d_segv_q    <= 1'b0;
    end else begin
      // Completion and fault indications are single-cycle pulses.
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_segv_q  <= 1'b0;
      d_segv_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            last_gnt_q <= gnt_d;
            if (sel_fault_d) begin
              // Bad address: report it without touching the memory bus.
              state_q <= FAULT;
              if (gnt_d == REQ_D) d_segv_q <= 1'b1;
              else                i_segv_q <= 1'b1;
            end else begin
              state_q    <= (gnt_d == REQ_D) ? BUSY_D : BUSY_I;
              mem_req_q  <= 1'b1;
              mem_addr_q <= sel_addr_d;
              mem_we_q   <= (gnt_d == REQ_D) && bus.d_we;
              if (gnt_d == REQ_D) mem_wdata_q <= bus.d_wdata;
              cnt_q      <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ack) begin
            if (state_q == BUSY_I) begin
              i_rdata_q <= bus.mem_rdata;
              i_valid_q <= 1'b1;
            end else begin
              // Stores complete without disturbing the last load data.
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
              d_valid_q <= 1'b1;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            // Watchdog expired: abandon the access and fault the owner.
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == BUSY_I) i_segv_q <= 1'b1;
            else                   d_segv_q <= 1'b1;
            state_q   <= FAULT;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        RESP, FAULT: state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.i_segv    = i_segv_q;
  assign bus.d_segv    = d_segv_q;
  assign bus.i_wait    = bus.i_req & ~i_valid_q & ~i_segv_q;
  assign bus.d_wait    = bus.d_req & ~d_valid_q & ~d_segv_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions with
// hand-computed latency/data, plus sequences for round-robin order and
// reset in the middle of an access.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LIMIT(32'h0001_0000), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Memory model: acks ack_delay cycles after mem_req rises (0 = same
  // cycle as the first mem_req cycle, -1 = never). A dropped request aborts.
  int          ack_delay     = 0;
  logic [31:0] mem_rdata_val = 32'h0;
  int          hi_cnt        = 0;

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      bus.mem_ack = (ack_delay >= 0) && (hi_cnt == ack_delay);
      hi_cnt++;
    end else begin
      bus.mem_ack = 1'b0;
      hi_cnt = 0;
    end
    bus.mem_rdata = bus.mem_ack ? mem_rdata_val : 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          exp_segv;
    int          exp_lat;
    int          exp_nreq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  // One isolated transaction: request raised in cycle N, then observed at
  // the negedge of each cycle N+k until its valid/segv pulse.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    int          nreq;
    bit          got;
    bit          seg;
    bit          bus_ok;
    bit          wait_ok;
    bit          owner_ok;
    logic [31:0] rd;
    lat = 0; nreq = 0; got = 0; seg = 0; bus_ok = 1; owner_ok = 1; rd = '0;
    @(negedge clk);
    ack_delay     = v.delay;
    mem_rdata_val = v.rdata;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    #1;
    wait_ok = ((v.is_d ? bus.d_wait : bus.i_wait) === 1'b1);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        nreq++;
        if (bus.mem_addr !== v.addr || bus.mem_we !== (v.is_d & v.we)) bus_ok = 0;
        if (v.is_d && v.we && bus.mem_wdata !== v.wdata) bus_ok = 0;
      end
      if ((bus.i_valid | bus.i_segv | bus.d_valid | bus.d_segv) === 1'b1) begin
        got = 1;
        lat = k;
        seg = v.is_d ? bus.d_segv : bus.i_segv;
        rd  = v.is_d ? bus.d_rdata : bus.i_rdata;
        if (v.is_d) owner_ok = ((bus.i_valid | bus.i_segv) === 1'b0) && ((bus.d_valid ^ bus.d_segv) === 1'b1);
        else        owner_ok = ((bus.d_valid | bus.d_segv) === 1'b0) && ((bus.i_valid ^ bus.i_segv) === 1'b1);
        if ((v.is_d ? bus.d_wait : bus.i_wait) !== 1'b0) wait_ok = 0;
      end else if ((v.is_d ? bus.d_wait : bus.i_wait) !== 1'b1) begin
        wait_ok = 0;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    if (!got) chk($sformatf("v%0d_no_pulse_within_budget", idx), 32'd0, 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_segv", idx), 32'(seg), 32'(v.exp_segv));
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
    chk($sformatf("v%0d_mem_req_cycles", idx), 32'(nreq), 32'(v.exp_nreq));
    chk($sformatf("v%0d_bus_fields", idx), 32'(bus_ok), 32'd1);
    chk($sformatf("v%0d_wait", idx), 32'(wait_ok), 32'd1);
    chk($sformatf("v%0d_pulse_owner", idx), 32'(owner_ok), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", idx),
        32'({bus.mem_req, bus.i_valid, bus.d_valid, bus.i_segv, bus.d_segv}), 32'd0);
  endtask

  logic [31:0] gaddr[4];
  int          ngr;
  int          npulse;
  bit          prev_req;
  bit          multi;

  initial begin
    //             is_d we  addr           wdata          rdata          dly segv lat nreq exp_rd
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'hFFFF_0000,  2, 1'b0,  4,  3, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF,  1, 1'b0,  3,  2, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678,  0, 1'b0,  2,  1, 32'h1234_5678};
    vecs[3]  = '{1'b1, 1'b1, 32'h0001_0000, 32'h1111_1111, 32'h0000_0000,  0, 1'b1,  1,  0, 32'h1234_5678};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0022, 32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1,  0, 32'h1234_5678};
    vecs[5]  = '{1'b0, 1'b0, 32'h0001_0004, 32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1,  0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,  0, 1'b1,  1,  0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'h7777_7777, -1, 1'b1, 17, 16, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_FFFC, 32'h0000_0000, 32'hCAFE_F00D,  3, 1'b0,  5,  4, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D,  0, 1'b0,  2,  1, 32'h0BAD_F00D};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_FFFF, 32'h2222_2222, 32'h0000_0000,  0, 1'b1,  1,  0, 32'hCAFE_F00D};

    // Reset state
    reset_dut();
    chk("rst_mem_req",   32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_i_rdata",   bus.i_rdata, 32'd0);
    chk("rst_d_rdata",   bus.d_rdata, 32'd0);
    chk("rst_pulses",    32'({bus.i_valid, bus.d_valid, bus.i_segv, bus.d_segv}), 32'd0);
    chk("rst_waits",     32'({bus.i_wait, bus.d_wait}), 32'd0);

    // Single transactions
    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Round robin with both requesters held and a zero-wait memory
    reset_dut();
    ack_delay = 0;
    mem_rdata_val = 32'h5555_AAAA;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    bus.i_req = 1'b1; bus.i_addr = 32'h24;
    for (int i = 0; i < 4; i++) gaddr[i] = 32'hFFFF_FFFF;
    ngr = 0; npulse = 0; prev_req = 0; multi = 0;
    for (int k = 0; k < 40 && npulse < 4; k++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && !prev_req && ngr < 4) begin
        gaddr[ngr] = bus.mem_addr;
        ngr++;
      end
      prev_req = (bus.mem_req === 1'b1);
      if ($countones({bus.i_valid, bus.d_valid, bus.i_segv, bus.d_segv}) > 1) multi = 1;
      if ((bus.i_valid | bus.d_valid) === 1'b1) npulse++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("rr_grants", 32'(ngr), 32'd4);
    chk("rr_pulses", 32'(npulse), 32'd4);
    chk("rr_grant0", gaddr[0], 32'h20);
    chk("rr_grant1", gaddr[1], 32'h24);
    chk("rr_grant2", gaddr[2], 32'h20);
    chk("rr_grant3", gaddr[3], 32'h24);
    chk("rr_one_pulse_per_cycle", 32'(multi), 32'd0);
    @(negedge clk);

    // Reset in the middle of a data access
    reset_dut();
    ack_delay = -1;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    repeat (3) @(negedge clk);
    chk("rm_busy_mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rm_async_drop", 32'(bus.mem_req), 32'd0);
    chk("rm_pulses", 32'({bus.i_valid, bus.d_valid, bus.i_segv, bus.d_segv}), 32'd0);
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    ack_delay = 0;
    mem_rdata_val = 32'h3C3C_3C3C;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ngr = 0; npulse = 0; prev_req = 0;
    gaddr[0] = 32'hFFFF_FFFF;
    gaddr[1] = 32'hFFFF_FFFF;
    for (int k = 0; k < 20 && npulse < 2; k++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && !prev_req && ngr < 2) begin
        gaddr[ngr] = bus.mem_addr;
        ngr++;
      end
      prev_req = (bus.mem_req === 1'b1);
      if ((bus.i_valid | bus.d_valid) === 1'b1) npulse++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("rm_first_grant_d", gaddr[0], 32'h40);
    chk("rm_second_grant_i", gaddr[1], 32'h50);
    chk("rm_d_rdata", bus.d_rdata, 32'h3C3C_3C3C);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the instruction-fetch requester (I) and the load/store requester (D) of the core.
- Generates the per-requester wait and segfault indications that the core control FSM consumes: `i_wait` drives wait_instr, `d_wait` drives wait_data, and the `*_segv` outputs drive the segv inputs.
- Performs bounds and alignment checks, round-robin arbitration and an ack-timeout watchdog.

Parameters:
- ADDR_W, 32, address width (byte addresses).
- DATA_W, 32, data width.
- MEM_LIMIT, 32'h0001_0000, first invalid byte address; any access at or above it faults.
- TIMEOUT, 16, maximum cycles `mem_req` is held without `mem_ack` before the access faults.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request; held until `i_wait` low
- i_addr  in  ADDR_W  fetch address; stable while `i_req` high
- i_rdata  out  DATA_W  fetched word; valid when `i_valid`
- i_valid  out  1  one-cycle completion pulse
- i_wait  out  1  `i_req & ~i_valid & ~i_segv`
- i_segv  out  1  one-cycle fault pulse for fetch
- d_req  in  1  data request; held until `d_wait` low
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when `d_valid`
- d_valid  out  1  one-cycle completion pulse
- d_wait  out  1  `d_req & ~d_valid & ~d_segv`
- d_segv  out  1  one-cycle fault pulse for data
- mem_req  out  1  memory request, held until `mem_ack`
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with `mem_ack`
- mem_ack  in  1  memory completion, single cycle

Behaviour:
- **Reset:** state IDLE. `mem_req`, `mem_we`, `i_valid`, `d_valid`, `i_segv` and `d_segv` are 0. `mem_addr`, `mem_wdata`, `i_rdata` and `d_rdata` are 0. `last_grant` = I, timeout counter = 0.
  - Reset mid-access drops `mem_req` immediately (asynchronous).
  - The memory model must treat a dropped request as aborted.
- **States:** IDLE, BUSY_I, BUSY_D, RESP, FAULT. All outputs are registered; only the `*_wait` outputs are combinational.
- **IDLE, grant rules:**
  - Only `i_req`: grant I.
  - Only `d_req`: grant D.
  - Both: grant the requester not equal to `last_grant`. After reset D wins first.
  - On grant, update `last_grant`.
- **IDLE, fault check on the granted requester:** fault if addr >= MEM_LIMIT or addr[1:0] != 0.
  - Fault: go to FAULT and set that requester's segv; no memory access is issued.
  - No fault: go to BUSY_I or BUSY_D. Register `mem_req`=1, `mem_addr`, and for D only `mem_we`=`d_we` and `mem_wdata`=`d_wdata`. Clear the timeout counter.
- **BUSY_x:**
  - `mem_req` stays high with addr/data frozen.
  - If `mem_ack`: capture `mem_rdata` into `x_rdata` (loads and fetches only; a store leaves `d_rdata` unchanged), set `x_valid`, drop `mem_req`/`mem_we`, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT-1 without ack: drop `mem_req`, set `x_segv`, go to FAULT.
  - `mem_ack` received outside BUSY is ignored.
- **RESP / FAULT:** one cycle. Clear the valid/segv pulse, return to IDLE.
  - The requester must deassert or change its request in the cycle after the pulse.
  - A request still high in IDLE is treated as new.
- **Latency:**
  - `req` sampled in IDLE at cycle N.
  - `mem_req` high at N+1.
  - Ack at cycle M gives valid at M+1.
  - Zero-wait memory (ack at N+1) gives valid and wait low at N+2.
  - Fault gives segv at N+1.
- **Simultaneous events:**
  - A losing requester keeps its wait high throughout and is granted at the next IDLE.
  - At most one of valid/segv pulses per cycle across both requesters.
- **Width rules:** the timeout counter is `$clog2(TIMEOUT+1)` bits and never wraps. The address compare is unsigned.

Test Plan:
- Reset, `i_req`=1, `i_addr`=0x10, ack one cycle after `mem_req` with `mem_rdata`=0xDEADBEEF -> `mem_req` at N+1, `i_valid`=1 with `i_rdata`=0xDEADBEEF at N+3, `i_wait` high N..N+2.
- After reset, `i_req` and `d_req` both held continuously (load 0x20, fetch 0x24), zero-wait memory -> grant order D, I, D, I; `mem_addr` alternates 0x20/0x24; never two grants back-to-back to the same requester.
- `d_req` store, `d_addr`=0x0001_0000 (=MEM_LIMIT) -> `d_segv` pulse at N+1, `mem_req` never asserted, `d_rdata` unchanged; `d_addr`=0x22 -> misaligned, `d_segv`.
- `i_req`, `mem_ack` never asserted, TIMEOUT=16 -> `mem_req` high exactly 16 cycles, then low with `i_segv` pulse, then IDLE.
- Store 0xA5A5A5A5 to 0x40 with ack after 3 cycles -> `mem_we`=1 and `mem_wdata` stable for 3 cycles, `d_valid` pulse, `d_rdata` still 0.
- `rst` asserted mid BUSY_D -> `mem_req`=0 in the same cycle; all pulses 0; after release with `d_req` and `i_req` both high, D is granted first.
